// File: rtl/lsu_ctrl.sv
// Load/store controller: splits one core request into little-endian byte transactions on a req/ack memory port.
// Latency: N+1 cycles for N bytes with zero-wait memory, +1 per cycle without mem_ack; rejects answer in 1 cycle. Backpressure: req_ready only in IDLE.
module lsu_ctrl #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]  state;
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] base;
    logic [31:0] wdat;
    logic [1:0]  idx;
    logic [1:0]  last;
    logic [31:0] asm_q;
    logic        err;

    logic [1:0]  n_last;
    logic [32:0] end_addr;
    logic        bad;

    always_comb begin
        case (req_size)
            2'b00:   n_last = 2'd0;
            2'b01:   n_last = 2'd1;
            default: n_last = 2'd3;
        endcase
    end

    // 33-bit sum so addresses near 2^32 cannot wrap into range
    assign end_addr = {1'b0, req_addr} + {31'd0, n_last} + 33'd1;
    assign bad = (req_size == 2'b11)
              || (req_size == 2'b01 && req_addr[0])
              || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
              || (end_addr > 33'(MEM_BYTES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            wr    <= 1'b0;
            sz    <= 2'd0;
            uns   <= 1'b0;
            base  <= 32'd0;
            wdat  <= 32'd0;
            idx   <= 2'd0;
            last  <= 2'd0;
            asm_q <= 32'd0;
            err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        wr    <= req_write;
                        sz    <= req_size;
                        uns   <= req_unsigned;
                        base  <= req_addr;
                        wdat  <= req_wdata;
                        last  <= n_last;
                        err   <= bad;
                        idx   <= 2'd0;
                        asm_q <= 32'd0;
                        state <= bad ? S_RESP : S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (mem_ack) begin
                        if (!wr)
                            asm_q[{idx, 3'b000} +: 8] <= mem_rdata;
                        if (idx == last)
                            state <= S_RESP;
                        else
                            idx <= idx + 2'd1;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign resp_err   = (state == S_RESP) && err;
    assign mem_read   = (state == S_ACCESS) && !wr;
    assign mem_write  = (state == S_ACCESS) && wr;
    assign mem_addr   = (state == S_ACCESS) ? base + {30'd0, idx} : 32'd0;
    assign mem_wdata  = (state == S_ACCESS) ? wdat[{idx, 3'b000} +: 8] : 8'd0;

    always_comb begin
        resp_rdata = 32'd0;
        if (state == S_RESP && !wr && !err) begin
            case (sz)
                2'b00:   resp_rdata = {{24{asm_q[7] & ~uns}}, asm_q[7:0]};
                2'b01:   resp_rdata = {{16{asm_q[15] & ~uns}}, asm_q[15:0]};
                default: resp_rdata = asm_q;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed vector table plus wait-state and mid-transaction reset sequences.
module tb_lsu_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_read, mem_write, mem_ack;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;
    int waits  = 0;
    int wcnt;
    int cyc = 0;

    logic [7:0] mem [0:1023];

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  dat;
        int          cy;
    } wlog_t;
    wlog_t wlog[$];

    typedef struct {
        logic        w;
        logic [1:0]  s;
        logic        u;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic        exp_er;
        int          exp_lat;
    } vec_t;
    vec_t vt[18];

    always #5 clk = ~clk;

    lsu_ctrl #(.MEM_BYTES(1024)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack)
    );

    // Memory model: ack after `waits` stall cycles on each byte
    assign mem_ack   = (mem_read || mem_write) && (wcnt == waits);
    assign mem_rdata = mem[mem_addr[9:0]];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt <= 0;
        end else begin
            cyc <= cyc + 1;
            if (mem_read || mem_write)
                wcnt <= mem_ack ? 0 : wcnt + 1;
            else
                wcnt <= 0;
            if (mem_write && mem_ack) begin
                mem[mem_addr[9:0]] <= mem_wdata;
                wlog.push_back('{mem_addr, mem_wdata, cyc});
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_req(input logic w, input logic [1:0] s, input logic u,
                           input logic [31:0] a, input logic [31:0] d,
                           output int lat, output logic [31:0] rd, output logic er,
                           output logic strobe_seen, output logic hold_bad,
                           output logic pulse_bad);
        logic        prev_wait;
        logic [31:0] prev_addr;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_size = s; req_unsigned = u;
        req_addr = a; req_wdata = d;
        lat = 999; rd = 32'd0; er = 1'b0;
        strobe_seen = 1'b0; hold_bad = 1'b0; pulse_bad = 1'b0;
        prev_wait = 1'b0; prev_addr = 32'd0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (mem_read || mem_write) strobe_seen = 1'b1;
            if (prev_wait && (mem_read || mem_write) && mem_addr != prev_addr) hold_bad = 1'b1;
            prev_wait = (mem_read || mem_write) && !mem_ack;
            prev_addr = mem_addr;
            if (resp_valid) begin
                lat = c; rd = resp_rdata; er = resp_err;
                break;
            end
            @(negedge clk);
        end
        if (lat != 999) begin
            @(negedge clk);
            if (resp_valid || !req_ready) pulse_bad = 1'b1;
        end
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        er, sseen, hbad, pbad, rv_seen;

        vt[0]  = '{1'b1, 2'd2, 1'b0, 32'h10,       32'h8000_7F01, 32'h0,         1'b0, 5};
        vt[1]  = '{1'b0, 2'd2, 1'b0, 32'h10,       32'h0,         32'h8000_7F01, 1'b0, 5};
        vt[2]  = '{1'b1, 2'd2, 1'b0, 32'h20,       32'h0000_80F0, 32'h0,         1'b0, 5};
        vt[3]  = '{1'b0, 2'd0, 1'b0, 32'h20,       32'h0,         32'hFFFF_FFF0, 1'b0, 2};
        vt[4]  = '{1'b0, 2'd0, 1'b1, 32'h20,       32'h0,         32'h0000_00F0, 1'b0, 2};
        vt[5]  = '{1'b0, 2'd1, 1'b0, 32'h20,       32'h0,         32'hFFFF_80F0, 1'b0, 3};
        vt[6]  = '{1'b0, 2'd1, 1'b1, 32'h20,       32'h0,         32'h0000_80F0, 1'b0, 3};
        vt[7]  = '{1'b0, 2'd1, 1'b0, 32'h21,       32'h0,         32'h0,         1'b1, 1};
        vt[8]  = '{1'b0, 2'd2, 1'b0, 32'h22,       32'h0,         32'h0,         1'b1, 1};
        vt[9]  = '{1'b0, 2'd3, 1'b0, 32'h0,        32'h0,         32'h0,         1'b1, 1};
        vt[10] = '{1'b0, 2'd0, 1'b0, 32'd1024,     32'h0,         32'h0,         1'b1, 1};
        vt[11] = '{1'b1, 2'd2, 1'b0, 32'd1020,     32'hA1B2_C3D4, 32'h0,         1'b0, 5};
        vt[12] = '{1'b0, 2'd2, 1'b1, 32'd1020,     32'h0,         32'hA1B2_C3D4, 1'b0, 5};
        vt[13] = '{1'b0, 2'd2, 1'b0, 32'd1021,     32'h0,         32'h0,         1'b1, 1};
        vt[14] = '{1'b1, 2'd0, 1'b0, 32'd1023,     32'h0000_005A, 32'h0,         1'b0, 2};
        vt[15] = '{1'b0, 2'd0, 1'b0, 32'd1023,     32'h0,         32'h0000_005A, 1'b0, 2};
        vt[16] = '{1'b1, 2'd2, 1'b0, 32'hFFFF_FFFC, 32'h1234_5678, 32'h0,        1'b1, 1};
        vt[17] = '{1'b1, 2'd0, 1'b0, 32'h30,       32'h0000_009C, 32'h0,         1'b0, 2};

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        @(negedge clk); @(negedge clk);
        chk("reset req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("reset resp_err", {31'd0, resp_err}, 32'd0);
        chk("reset resp_rdata", resp_rdata, 32'd0);
        chk("reset strobes", {30'd0, mem_read, mem_write}, 32'd0);
        chk("reset mem_addr", mem_addr, 32'd0);
        chk("reset mem_wdata", {24'd0, mem_wdata}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            wlog.delete();
            run_req(vt[i].w, vt[i].s, vt[i].u, vt[i].a, vt[i].d, lat, rd, er, sseen, hbad, pbad);
            chk($sformatf("vec%0d rdata", i), rd, vt[i].exp_rd);
            chk($sformatf("vec%0d err", i), {31'd0, er}, {31'd0, vt[i].exp_er});
            chk($sformatf("vec%0d latency", i), lat, vt[i].exp_lat);
            chk($sformatf("vec%0d strobe", i), {31'd0, sseen}, {31'd0, ~vt[i].exp_er});
            chk($sformatf("vec%0d one-pulse", i), {31'd0, pbad}, 32'd0);
            if (i == 0) begin
                chk("store0 byte count", wlog.size(), 4);
                if (wlog.size() == 4) begin
                    chk("store0 b0 addr", wlog[0].addr, 32'h10);
                    chk("store0 b0 dat", {24'd0, wlog[0].dat}, 32'h01);
                    chk("store0 b1 addr", wlog[1].addr, 32'h11);
                    chk("store0 b1 dat", {24'd0, wlog[1].dat}, 32'h7F);
                    chk("store0 b2 addr", wlog[2].addr, 32'h12);
                    chk("store0 b2 dat", {24'd0, wlog[2].dat}, 32'h00);
                    chk("store0 b3 addr", wlog[3].addr, 32'h13);
                    chk("store0 b3 dat", {24'd0, wlog[3].dat}, 32'h80);
                    chk("store0 consecutive", wlog[3].cy - wlog[0].cy, 3);
                end
            end
        end

        // Two stall cycles before every byte of a word load
        waits = 2;
        run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, rd, er, sseen, hbad, pbad);
        chk("wait rdata", rd, 32'h8000_7F01);
        chk("wait latency", lat, 13);
        chk("wait addr hold", {31'd0, hbad}, 32'd0);
        chk("wait err", {31'd0, er}, 32'd0);
        waits = 0;

        // Reset during the third byte of a word store
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h50; req_wdata = 32'h1122_3344;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst-mid write before", {31'd0, mem_write}, 32'd1);
        chk("rst-mid addr before", mem_addr, 32'h52);
        chk("rst-mid wdata before", {24'd0, mem_wdata}, 32'h22);
        rst = 1'b1;
        #1;
        chk("rst-mid strobes drop", {30'd0, mem_read, mem_write}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rv_seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (resp_valid) rv_seen = 1'b1;
        end
        chk("rst-mid no resp", {31'd0, rv_seen}, 32'd0);
        chk("rst-mid req_ready", {31'd0, req_ready}, 32'd1);
        run_req(1'b0, 2'd0, 1'b0, 32'h30, 32'h0, lat, rd, er, sseen, hbad, pbad);
        chk("post-rst load rdata", rd, 32'hFFFF_FF9C);
        chk("post-rst load latency", lat, 2);
        chk("post-rst load err", {31'd0, er}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
